// File: rtl/led_status_serializer.sv
`default_nettype none
// =============================================================================
// Module   : led_status_serializer
// Brief    : Turns a per-LED 2-bit mode vector into serial frames for a chain of
//            shift-register LED drivers (LED_CLK / LED_OUT / LED_LATCH / LED_OE).
//            Optional macro LED_DIM_EN adds a DIM input that PWMs LED_OE.
// Revision : 1.0 - initial release
// =============================================================================
module led_status_serializer #(
   parameter int NUM_LEDS = 24,
   parameter int CLK_DIV  = 1,
   parameter int SLOW_DIV = 500000,
   parameter int FAST_DIV = 125000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [2*NUM_LEDS-1:0] LED_MODE,
   input  logic                  FORCE_UPDATE,
`ifdef LED_DIM_EN
   input  logic [3:0]            DIM,
`endif
   output logic                  BUSY,
   output logic                  LED_CLK,
   output logic                  LED_OUT,
   output logic                  LED_LATCH,
   output logic                  LED_OE
);

   localparam int c_BIT_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int c_DIV_W  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
   localparam int c_SLOW_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam int c_FAST_W = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;

   localparam logic [c_BIT_W-1:0]  c_BIT_TOP   = c_BIT_W'(NUM_LEDS - 1);
   localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_SLOW_W-1:0] c_SLOW_LAST = c_SLOW_W'(SLOW_DIV - 1);
   localparam logic [c_FAST_W-1:0] c_FAST_LAST = c_FAST_W'(FAST_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_SHIFT_LO = 3'd2,
      S_SHIFT_HI = 3'd3,
      S_LATCH    = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [c_SLOW_W-1:0]   r_slow_cnt;
   logic [c_FAST_W-1:0]   r_fast_cnt;
   logic                  r_slow_phase;
   logic                  r_fast_phase;
   logic [c_DIV_W-1:0]    r_div_cnt;
   logic [c_BIT_W-1:0]    r_bit_idx;
   logic [NUM_LEDS-1:0]   r_shreg;
   logic [NUM_LEDS-1:0]   r_last_sent;
   logic                  r_pending;
   logic                  r_busy;
   logic                  r_led_clk;
   logic                  r_led_out;
   logic                  r_led_latch;
   logic                  r_oe_en;
   logic [NUM_LEDS-1:0]   w_frame;
   logic                  w_start;
   logic                  w_div_last;
   logic                  w_bit_step;
   logic                  w_busy_nxt;
   logic                  w_led_clk_nxt;
   logic                  w_led_latch_nxt;
   logic                  w_latch_done;

   // Blink timebases run free in every state
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_slow_cnt   <= '0;
         r_fast_cnt   <= '0;
         r_slow_phase <= 1'b0;
         r_fast_phase <= 1'b0;
      end else begin
         if (r_slow_cnt == c_SLOW_LAST) begin
            r_slow_cnt   <= '0;
            r_slow_phase <= ~r_slow_phase;
         end else begin
            r_slow_cnt <= r_slow_cnt + 1'b1;
         end
         if (r_fast_cnt == c_FAST_LAST) begin
            r_fast_cnt   <= '0;
            r_fast_phase <= ~r_fast_phase;
         end else begin
            r_fast_cnt <= r_fast_cnt + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_frame
      assign w_frame[gi] = LED_MODE[2*gi+1]
                         ? (LED_MODE[2*gi] ? r_fast_phase : r_slow_phase)
                         : LED_MODE[2*gi];
   end

   assign w_start      = (w_frame != r_last_sent) || r_pending;
   assign w_div_last   = (r_div_cnt == c_DIV_LAST);
   assign w_bit_step   = (r_state == S_SHIFT_HI) && w_div_last && (r_bit_idx != '0);
   assign w_latch_done = (r_state == S_LATCH) && w_div_last;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_busy_nxt      = 1'b0;
      w_led_clk_nxt   = 1'b0;
      w_led_latch_nxt = 1'b0;
      case (r_state)
         S_IDLE:     if (w_start) w_next_state = S_LOAD;
         S_LOAD:     w_next_state = S_SHIFT_LO;
         S_SHIFT_LO: if (w_div_last) w_next_state = S_SHIFT_HI;
         S_SHIFT_HI: if (w_div_last) w_next_state = (r_bit_idx == '0) ? S_LATCH : S_SHIFT_LO;
         S_LATCH:    if (w_div_last) w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
      // Outputs are registered from the next state so they line up with it
      w_busy_nxt      = (w_next_state != S_IDLE);
      w_led_clk_nxt   = (w_next_state == S_SHIFT_HI);
      w_led_latch_nxt = (w_next_state == S_LATCH);
   end

   always_ff @(posedge CLK) begin
      if (RST || (r_state == S_IDLE) || (w_next_state != r_state)) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_shreg     <= '0;
         r_last_sent <= '0;
         r_bit_idx   <= '0;
         r_led_out   <= 1'b0;
         r_pending   <= 1'b1;
      end else begin
         if (r_state == S_LOAD) begin
            r_shreg     <= w_frame;
            r_last_sent <= w_frame;
            r_bit_idx   <= c_BIT_TOP;
            r_led_out   <= w_frame[NUM_LEDS-1];
         end else if (w_bit_step) begin
            r_bit_idx <= r_bit_idx - 1'b1;
            r_led_out <= r_shreg[r_bit_idx - 1'b1];
         end
         // A request landing on the LOAD cycle survives as one extra frame
         if (FORCE_UPDATE) begin
            r_pending <= 1'b1;
         end else if (r_state == S_LOAD) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_busy      <= 1'b0;
         r_led_clk   <= 1'b0;
         r_led_latch <= 1'b0;
         r_oe_en     <= 1'b0;
      end else begin
         r_busy      <= w_busy_nxt;
         r_led_clk   <= w_led_clk_nxt;
         r_led_latch <= w_led_latch_nxt;
         r_oe_en     <= r_oe_en | w_latch_done;
      end
   end

`ifdef LED_DIM_EN
   logic [3:0] r_pwm_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end
   end

   assign LED_OE = r_oe_en ? ~(r_pwm_cnt <= DIM) : 1'b1;
`else
   assign LED_OE = ~r_oe_en;
`endif

   assign BUSY      = r_busy;
   assign LED_CLK   = r_led_clk;
   assign LED_OUT   = r_led_out;
   assign LED_LATCH = r_led_latch;

endmodule

`default_nettype wire

// File: tb/tb_led_status_serializer.sv
`default_nettype none
// =============================================================================
// Module   : tb_led_status_serializer
// Brief    : Self-checking bench for led_status_serializer (random + directed).
// Revision : 1.0 - initial release
// =============================================================================
module tb_led_status_serializer;

   localparam int N        = 8;
   localparam int CD       = 2;
   localparam int SDIV     = 300;
   localparam int FDIV     = 90;
   localparam int BSDIV    = 20;
   localparam int BUSY_LEN = 1 + 2*CD*N + CD;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic [2*N-1:0] LED_MODE = '0;
   logic           FORCE_UPDATE = 1'b0;
   logic           BUSY, LED_CLK, LED_OUT, LED_LATCH, LED_OE;
   logic [2*N-1:0] LED_MODE_B = 16'h0002;
   logic           FORCE_B = 1'b0;
   logic           BUSY_B, LED_CLK_B, LED_OUT_B, LED_LATCH_B, LED_OE_B;
`ifdef LED_DIM_EN
   logic [3:0]     DIM = 4'd15;
`endif

   int checks = 0;
   int failures = 0;
   logic [N-1:0] cur_bits = '0;

   always #5 CLK = ~CLK;

   led_status_serializer #(.NUM_LEDS(N), .CLK_DIV(CD), .SLOW_DIV(SDIV), .FAST_DIV(FDIV)) u_dut (
      .CLK(CLK), .RST(RST), .LED_MODE(LED_MODE), .FORCE_UPDATE(FORCE_UPDATE),
`ifdef LED_DIM_EN
      .DIM(DIM),
`endif
      .BUSY(BUSY), .LED_CLK(LED_CLK), .LED_OUT(LED_OUT), .LED_LATCH(LED_LATCH), .LED_OE(LED_OE));

   led_status_serializer #(.NUM_LEDS(N), .CLK_DIV(1), .SLOW_DIV(BSDIV), .FAST_DIV(1000)) u_dut_b (
      .CLK(CLK), .RST(RST), .LED_MODE(LED_MODE_B), .FORCE_UPDATE(FORCE_B),
`ifdef LED_DIM_EN
      .DIM(DIM),
`endif
      .BUSY(BUSY_B), .LED_CLK(LED_CLK_B), .LED_OUT(LED_OUT_B), .LED_LATCH(LED_LATCH_B), .LED_OE(LED_OE_B));

   // Cycles since reset; blink phase of a divider D is (t / D) mod 2
   int unsigned t = 0;
   always @(posedge CLK) begin
      if (RST) t <= 0;
      else     t <= t + 1;
   end

   function automatic logic [N-1:0] model_frame(input logic [2*N-1:0] m, input int unsigned tc,
                                                input int unsigned sd, input int unsigned fd);
      logic [N-1:0] f;
      for (int i = 0; i < N; i++) begin
         case (m[2*i +: 2])
            2'b00:   f[i] = 1'b0;
            2'b01:   f[i] = 1'b1;
            2'b10:   f[i] = ((tc / sd) % 2) != 0;
            default: f[i] = ((tc / fd) % 2) != 0;
         endcase
      end
      return f;
   endfunction

   function automatic logic [2*N-1:0] on_mode(input logic [N-1:0] b);
      logic [2*N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) m[2*i +: 2] = {1'b0, b[i]};
      return m;
   endfunction

   typedef struct {
      logic [N-1:0] bits;
      logic [N-1:0] exp;
      int           nbits;
      int           busy_len;
      int           latch_len;
      int           unstable;
      int unsigned  start_t;
      int unsigned  end_t;
      logic         oe_last;
      logic         oe_after;
   } frame_t;

   frame_t frames[$];
   frame_t cur;
   logic   p_busy = 1'b0, p_clk = 1'b0, p_out = 1'b0, p_oe = 1'b1;

   // Serial bus monitor: records each frame as the driver chain would see it
   always @(negedge CLK) begin
      if (BUSY && !p_busy) begin
         cur = '{default: 0};
         cur.exp = model_frame(LED_MODE, t, SDIV, FDIV);
         cur.start_t = t;
      end
      if (BUSY) cur.busy_len = cur.busy_len + 1;
      if (LED_CLK && !p_clk) begin
         cur.bits  = {cur.bits[N-2:0], LED_OUT};
         cur.nbits = cur.nbits + 1;
         if (LED_OUT !== p_out) cur.unstable = cur.unstable + 1;
      end
      if (LED_LATCH) cur.latch_len = cur.latch_len + 1;
      if (!BUSY && p_busy) begin
         cur.end_t    = t;
         cur.oe_last  = p_oe;
         cur.oe_after = LED_OE;
         frames.push_back(cur);
      end
      p_busy = BUSY; p_clk = LED_CLK; p_out = LED_OUT; p_oe = LED_OE;
   end

   logic [N-1:0] b_bits = '0;
   int unsigned  b_t = 0;
   logic         pb_busy = 1'b0, pb_clk = 1'b0;
   int unsigned  bq_t[$];
   logic [N-1:0] bq_bits[$];

   always @(negedge CLK) begin
      if (BUSY_B && !pb_busy) begin b_t = t; b_bits = '0; end
      if (LED_CLK_B && !pb_clk) b_bits = {b_bits[N-2:0], LED_OUT_B};
      if (!BUSY_B && pb_busy) begin bq_t.push_back(b_t); bq_bits.push_back(b_bits); end
      pb_busy = BUSY_B; pb_clk = LED_CLK_B;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge CLK); #1;
         if (frames.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic pulse_force();
      FORCE_UPDATE = 1'b1; cycles(1); FORCE_UPDATE = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; LED_MODE = 16'h5555; cur_bits = 8'hFF;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({BUSY, LED_CLK, LED_OUT, LED_LATCH, LED_OE} !== 5'b00001) begin
         failures++; $display("FAIL reset_outputs: got %b, expected 00001", {BUSY, LED_CLK, LED_OUT, LED_LATCH, LED_OE});
      end
      @(posedge CLK); #1; RST = 1'b0;
      frames.delete();
   endtask

   task automatic test_first_frame();
      bit ok; frame_t f;
      wait_frames(1, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL first_frame_timeout: got no frame, expected one"); return; end
      f = frames[0];
      checks++; if (f.start_t !== 1) begin failures++; $display("FAIL first_load_cycle: got %0d, expected 1", f.start_t); end
      checks++; if (f.busy_len !== BUSY_LEN) begin failures++; $display("FAIL busy_len: got %0d, expected %0d", f.busy_len, BUSY_LEN); end
      checks++; if (f.nbits !== N) begin failures++; $display("FAIL clk_edges: got %0d, expected %0d", f.nbits, N); end
      checks++; if (f.bits !== 8'hFF) begin failures++; $display("FAIL all_on_bits: got %h, expected ff", f.bits); end
      checks++; if (f.latch_len !== CD) begin failures++; $display("FAIL latch_width: got %0d, expected %0d", f.latch_len, CD); end
      checks++; if (f.oe_last !== 1'b1 || f.oe_after !== 1'b0) begin
         failures++; $display("FAIL oe_fall: got last=%b after=%b, expected 1 then 0", f.oe_last, f.oe_after);
      end
      checks++; if (f.unstable !== 0) begin failures++; $display("FAIL out_setup: got %0d unstable bits, expected 0", f.unstable); end
   endtask

   task automatic test_single_led();
      bit ok;
      frames.delete();
      LED_MODE = 16'h4000; cur_bits = 8'h80;
      wait_frames(1, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_timeout: got no frame, expected one"); return; end
      checks++; if (frames[0].bits !== 8'h80) begin failures++; $display("FAIL single_bits: got %b, expected 10000000", frames[0].bits); end
      cycles(1000);
      checks++; if (frames.size() !== 1) begin failures++; $display("FAIL hold_no_resend: got %0d frames, expected 1", frames.size()); end
      checks++; if (LED_OE !== 1'b0) begin failures++; $display("FAIL oe_stays_low: got %b, expected 0", LED_OE); end
   endtask

   task automatic test_midshift();
      bit ok; logic [N-1:0] b2, b3;
      frames.delete();
      b2 = cur_bits ^ N'($urandom_range(1, 255));
      b3 = b2 ^ N'($urandom_range(1, 255));
      LED_MODE = on_mode(b2);
      cycles(10);
      LED_MODE = on_mode(b3); cur_bits = b3;
      wait_frames(2, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midshift_timeout: got %0d frames, expected 2", frames.size()); return; end
      checks++; if (frames[0].bits !== b2) begin failures++; $display("FAIL inflight_bits: got %h, expected %h", frames[0].bits, b2); end
      checks++; if (frames[1].bits !== b3) begin failures++; $display("FAIL second_bits: got %h, expected %h", frames[1].bits, b3); end
      checks++; if (frames[1].start_t !== frames[0].end_t + 1) begin
         failures++; $display("FAIL no_idle_gap: got load at %0d, expected %0d", frames[1].start_t, frames[0].end_t + 1);
      end
      cycles(100);
      checks++; if (frames.size() !== 2) begin failures++; $display("FAIL midshift_count: got %0d, expected 2", frames.size()); end
   endtask

   task automatic test_force_busy();
      bit ok;
      frames.delete();
      pulse_force();
      cycles(6); pulse_force();
      cycles(7); pulse_force();
      cycles(4); pulse_force();
      wait_frames(2, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL force_timeout: got %0d frames, expected 2", frames.size()); return; end
      cycles(200);
      checks++; if (frames.size() !== 2) begin failures++; $display("FAIL force_busy_count: got %0d, expected 2", frames.size()); end
      checks++; if (frames[1].bits !== cur_bits) begin failures++; $display("FAIL force_bits: got %h, expected %h", frames[1].bits, cur_bits); end
   endtask

   task automatic test_force_load();
      bit ok; int unsigned tc;
      frames.delete();
      tc = t;
      FORCE_UPDATE = 1'b1; cycles(1);
      FORCE_UPDATE = 1'b0;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL force_idle_busy: got %b, expected 0", BUSY); end
      cycles(1);
      FORCE_UPDATE = 1'b1;
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL force_load_busy: got %b, expected 1", BUSY); end
      cycles(1);
      FORCE_UPDATE = 1'b0;
      wait_frames(2, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL force_load_timeout: got %0d frames, expected 2", frames.size()); return; end
      checks++; if (frames[0].start_t !== tc + 2) begin failures++; $display("FAIL force_idle_start: got %0d, expected %0d", frames[0].start_t, tc + 2); end
      cycles(200);
      checks++; if (frames.size() !== 2) begin failures++; $display("FAIL force_load_count: got %0d, expected 2", frames.size()); end
   endtask

   task automatic test_random();
      logic [N-1:0] rb; int n;
      frames.delete();
      for (int k = 0; k < 6; k++) begin
         LED_MODE = 16'($urandom);
         cycles($urandom_range(40, 120));
      end
      rb = N'($urandom); LED_MODE = on_mode(rb); cur_bits = rb;
      cycles(150);
      checks++; if (frames.size() == 0) begin failures++; $display("FAIL random_frames: got 0 frames, expected some"); end
      foreach (frames[i]) begin
         checks++;
         if (frames[i].bits !== frames[i].exp || frames[i].busy_len !== BUSY_LEN || frames[i].latch_len !== CD) begin
            failures++;
            $display("FAIL random_frame%0d: got bits=%h busy=%0d latch=%0d, expected bits=%h busy=%0d latch=%0d",
                     i, frames[i].bits, frames[i].busy_len, frames[i].latch_len, frames[i].exp, BUSY_LEN, CD);
         end
      end
      n = frames.size();
      if (n > 0) begin
         checks++; if (frames[$].bits !== rb) begin failures++; $display("FAIL random_final: got %h, expected %h", frames[$].bits, rb); end
      end
      cycles(150);
      checks++; if (frames.size() !== n) begin failures++; $display("FAIL random_quiet: got %0d frames, expected %0d", frames.size(), n); end
   endtask

   task automatic test_slow_blink();
      RST = 1'b1; cycles(2); RST = 1'b0;
      bq_t.delete(); bq_bits.delete(); frames.delete();
      cycles(130);
      checks++; if (bq_t.size() < 5) begin failures++; $display("FAIL blink_frames: got %0d, expected at least 5", bq_t.size()); end
      checks++; if (bq_t.size() > 0 && bq_t[0] !== 1) begin failures++; $display("FAIL blink_first: got %0d, expected 1", bq_t[0]); end
      for (int k = 1; k < bq_t.size(); k++) begin
         checks++;
         if (bq_t[k] - bq_t[k-1] !== BSDIV || bq_bits[k] !== N'(k % 2)) begin
            failures++;
            $display("FAIL blink_frame%0d: got gap=%0d bits=%h, expected gap=%0d bits=%h",
                     k, bq_t[k] - bq_t[k-1], bq_bits[k], BSDIV, N'(k % 2));
         end
      end
   endtask

   task automatic test_reset_midframe();
      bit ok; int rises; logic pc;
      cycles(60);
      frames.delete();
      pulse_force();
      rises = 0; pc = 1'b0;
      for (int i = 0; i < 100 && rises < 5; i++) begin
         @(negedge CLK);
         if (LED_CLK && !pc) rises++;
         pc = LED_CLK;
      end
      checks++;
      if (rises != 5) begin failures++; $display("FAIL midframe_reach: got %0d rises, expected 5", rises); return; end
      @(posedge CLK); #1; RST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({BUSY, LED_CLK, LED_OUT, LED_LATCH, LED_OE} !== 5'b00001) begin
         failures++; $display("FAIL midframe_reset: got %b, expected 00001", {BUSY, LED_CLK, LED_OUT, LED_LATCH, LED_OE});
      end
      @(posedge CLK); #1; RST = 1'b0;
      frames.delete();
      wait_frames(1, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL resend_timeout: got no frame, expected one"); return; end
      checks++;
      if (frames[0].nbits !== N || frames[0].bits !== cur_bits || frames[0].latch_len !== CD || frames[0].oe_after !== 1'b0) begin
         failures++;
         $display("FAIL resend_frame: got n=%0d bits=%h latch=%0d oe=%b, expected n=%0d bits=%h latch=%0d oe=0",
                  frames[0].nbits, frames[0].bits, frames[0].latch_len, frames[0].oe_after, N, cur_bits, CD);
      end
      checks++; if (frames[0].oe_last !== 1'b1) begin failures++; $display("FAIL oe_relatch: got %b, expected 1", frames[0].oe_last); end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_single_led();
      test_midshift();
      test_force_busy();
      test_force_load();
      test_random();
      test_slow_blink();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
